// File: rtl/fixed_accumulator.sv
// Streaming accumulator: sums IN_DEPTH accepted input beats into one result
// and presents it as a single registered output beat (valid/ready both sides).
module fixed_accumulator #(
   parameter int IN_DEPTH  = 4,
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 data_out_valid,
   input  logic                 data_out_ready
);
   localparam int               CNT_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

   logic [CNT_W-1:0]     r_cnt;
   logic [OUT_WIDTH-1:0] r_acc;
   logic [OUT_WIDTH-1:0] r_data_out;
   logic                 r_data_out_valid;

   logic                 w_in_fire;
   logic                 w_out_fire;
   logic                 w_last_beat;
   logic [OUT_WIDTH-1:0] w_sum;

   // Input stalls only while a finished result is held and not being taken.
   assign data_in_ready  = !r_data_out_valid || data_out_ready;
   assign w_in_fire      = data_in_valid && data_in_ready;
   assign w_out_fire     = r_data_out_valid && data_out_ready;
   assign w_last_beat    = (r_cnt == LAST_CNT);
   assign w_sum          = r_acc + OUT_WIDTH'(data_in);

   assign data_out       = r_data_out;
   assign data_out_valid = r_data_out_valid;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_cnt            <= '0;
         r_acc            <= '0;
         r_data_out       <= '0;
         r_data_out_valid <= 1'b0;
      end else begin
         if (w_out_fire) begin
            r_data_out_valid <= 1'b0;
         end
         if (w_in_fire) begin
            if (w_last_beat) begin
               // Overrides the clear above: a result delivered and a new one
               // completed in the same cycle keeps valid high with no bubble.
               r_data_out       <= w_sum;
               r_data_out_valid <= 1'b1;
               r_acc            <= '0;
               r_cnt            <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
